// File: rtl/sem_inject_sequencer.sv
// Fault-injection campaign sequencer: emits SEM monitor commands (I, N <lfa>, O),
// waits on the injection status, observes the DUT error flag and counts injections and failures.
module sem_inject_sequencer #(
    parameter int ADDR_W         = 40,
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] step_i,
    input  logic [CNT_W-1:0]  num_inj_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic              status_injection_i,
    input  logic              dut_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  inj_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              timeout_o
);

    localparam int NDIG  = ADDR_W / 4;
    localparam int IDX_W = $clog2(NDIG + 3);
    localparam int WMAX  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int WC_W  = $clog2(WMAX + 1);

    localparam logic [IDX_W-1:0] IDX_LAST_DIG = IDX_W'(NDIG + 1);
    localparam logic [IDX_W-1:0] IDX_CR       = IDX_W'(NDIG + 2);
    localparam logic [IDX_W-1:0] IDX_FIRST_DIG = IDX_W'(2);
    localparam logic [WC_W-1:0]  SETTLE_LAST  = WC_W'(SETTLE_CYCLES - 1);
    localparam logic [WC_W-1:0]  TMO_LAST     = WC_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_I  = 8'h49;
    localparam logic [7:0] CH_N  = 8'h4E;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SIDLE,
        ST_SINJ,
        ST_WHI,
        ST_WLO,
        ST_SOBS,
        ST_SETTLE,
        ST_CHECK,
        ST_SABORT,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] step_q;
    logic [ADDR_W-1:0] sh_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  inj_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WC_W-1:0]   wait_q;
    logic              err_flag_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;

    logic [CNT_W-1:0]  inj_cnt_d;
    logic [CNT_W-1:0]  err_cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] sh_d;
    logic [3:0]        dig_nx;
    logic              accept;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        hex_ascii = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    always_comb begin
        inj_cnt_d = (inj_cnt_q == '1) ? inj_cnt_q : inj_cnt_q + CNT_W'(1);
        err_cnt_d = (err_flag_q && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        addr_d    = addr_q + step_q;
        accept    = tx_valid_q & tx_ready_i;
        // The shifter advances only once a digit has gone out, so the space byte sees the MS nibble.
        sh_d      = (idx_q >= IDX_FIRST_DIG) ? (sh_q << 4) : sh_q;
        dig_nx    = sh_d[ADDR_W-1 -: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            step_q     <= '0;
            sh_q       <= '0;
            num_q      <= '0;
            inj_cnt_q  <= '0;
            err_cnt_q  <= '0;
            idx_q      <= '0;
            wait_q     <= '0;
            err_flag_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q    <= base_addr_i;
                        step_q    <= step_i;
                        num_q     <= num_inj_i;
                        inj_cnt_q <= '0;
                        err_cnt_q <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (num_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CH_I;
                        idx_q      <= '0;
                        state_q    <= ST_SIDLE;
                    end
                end
                ST_SIDLE: begin
                    if (accept) begin
                        if (idx_q == '0) begin
                            idx_q     <= IDX_W'(1);
                            tx_data_q <= CH_CR;
                        end else begin
                            idx_q     <= '0;
                            tx_data_q <= CH_N;
                            sh_q      <= addr_q;
                            state_q   <= ST_SINJ;
                        end
                    end
                end
                ST_SINJ: begin
                    if (accept) begin
                        idx_q <= idx_q + IDX_W'(1);
                        sh_q  <= sh_d;
                        if (idx_q == IDX_CR) begin
                            tx_valid_q <= 1'b0;
                            wait_q     <= '0;
                            state_q    <= ST_WHI;
                        end else if (idx_q == '0) begin
                            tx_data_q <= CH_SP;
                        end else if (idx_q == IDX_LAST_DIG) begin
                            tx_data_q <= CH_CR;
                        end else begin
                            tx_data_q <= hex_ascii(dig_nx);
                        end
                    end
                end
                ST_WHI: begin
                    if (status_injection_i) begin
                        wait_q  <= '0;
                        state_q <= ST_WLO;
                    end else if (wait_q == TMO_LAST) begin
                        timeout_q  <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CH_O;
                        idx_q      <= '0;
                        state_q    <= ST_SABORT;
                    end else begin
                        wait_q <= wait_q + WC_W'(1);
                    end
                end
                ST_WLO: begin
                    if (!status_injection_i) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CH_O;
                        idx_q      <= '0;
                        state_q    <= ST_SOBS;
                    end else if (wait_q == TMO_LAST) begin
                        timeout_q  <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CH_O;
                        idx_q      <= '0;
                        state_q    <= ST_SABORT;
                    end else begin
                        wait_q <= wait_q + WC_W'(1);
                    end
                end
                ST_SOBS: begin
                    if (accept) begin
                        if (idx_q == '0) begin
                            idx_q     <= IDX_W'(1);
                            tx_data_q <= CH_CR;
                        end else begin
                            tx_valid_q <= 1'b0;
                            wait_q     <= '0;
                            err_flag_q <= 1'b0;
                            state_q    <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    err_flag_q <= err_flag_q | dut_err_i;
                    if (wait_q == SETTLE_LAST) begin
                        state_q <= ST_CHECK;
                    end else begin
                        wait_q <= wait_q + WC_W'(1);
                    end
                end
                ST_CHECK: begin
                    inj_cnt_q <= inj_cnt_d;
                    err_cnt_q <= err_cnt_d;
                    addr_q    <= addr_d;
                    if (inj_cnt_d == num_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= CH_N;
                        idx_q      <= '0;
                        sh_q       <= addr_d;
                        state_q    <= ST_SINJ;
                    end
                end
                ST_SABORT: begin
                    if (accept) begin
                        if (idx_q == '0) begin
                            idx_q     <= IDX_W'(1);
                            tx_data_q <= CH_CR;
                        end else begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign inj_count_o = inj_cnt_q;
    assign err_count_o = err_cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sem_inject_sequencer.sv
// Bench for sem_inject_sequencer: vector table of campaigns plus hand-written reset,
// zero-length and start-while-busy sequences; a negedge environment drives ready/status/err.
module tb_sem_inject_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [39:0] base_addr_i;
    logic [39:0] step_i;
    logic [15:0] num_inj_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        status_injection_i;
    logic        dut_err_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] inj_count_o;
    logic [15:0] err_count_o;
    logic        timeout_o;

    sem_inject_sequencer #(
        .ADDR_W(40), .CNT_W(16), .SETTLE_CYCLES(20), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .base_addr_i(base_addr_i), .step_i(step_i), .num_inj_i(num_inj_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .status_injection_i(status_injection_i), .dut_err_i(dut_err_i),
        .busy_o(busy_o), .done_o(done_o), .inj_count_o(inj_count_o),
        .err_count_o(err_count_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] base;
        logic [39:0] step;
        logic [15:0] num;
        bit          stall;
        int          err_at;
        bit          no_status;
        string       exp;      // '~' stands for carriage return
        int          e_inj;
        int          e_err;
        bit          e_tmo;
    } vec_t;

    vec_t vecs[5];

    int total = 0;
    int bad   = 0;

    // environment state
    logic [7:0] rx_q[$];
    bit         stall_en = 0;
    bit         no_status = 0;
    int         err_at = 0;
    int         st_dly = 0, st_hi = 0, er_dly = 0;
    int         obs_n = 0, done_n = 0, stab_bad = 0;
    int         cyc = 0, ncr_cyc = 0, o_first_cyc = 0;
    bit         msg_start = 1;
    logic [7:0] msg_first = 8'h00;
    bit         prev_vld = 0, prev_stall = 0;
    logic [7:0] prev_dat = 8'h00;

    initial begin
        tx_ready_i = 1'b1;
        status_injection_i = 1'b0;
        dut_err_i = 1'b0;
        forever begin
            @(negedge clk);
            tx_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (st_dly > 0) begin
                st_dly--;
                if (st_dly == 0) begin
                    status_injection_i = 1'b1;
                    st_hi = 3;
                end
            end else if (st_hi > 0) begin
                st_hi--;
                if (st_hi == 0) status_injection_i = 1'b0;
            end
            if (er_dly > 0) begin
                er_dly--;
                dut_err_i = (er_dly == 0);
            end else begin
                dut_err_i = 1'b0;
            end
            #1;
            cyc++;
            if (!rst) begin
                if (prev_stall && !(tx_valid_o && tx_data_o === prev_dat)) stab_bad++;
                if (tx_valid_o && tx_ready_i) begin
                    rx_q.push_back(tx_data_o);
                    if (msg_start) msg_first = tx_data_o;
                    msg_start = (tx_data_o == 8'h0D);
                    if (tx_data_o == 8'h0D && msg_first == "N") begin
                        ncr_cyc = cyc;
                        if (!no_status) st_dly = 5;
                    end
                    if (tx_data_o == 8'h0D && msg_first == "O") begin
                        obs_n++;
                        if (obs_n == err_at) er_dly = 3;
                    end
                end
                if (tx_valid_o && !prev_vld && tx_data_o == "O") o_first_cyc = cyc;
                if (done_o) done_n++;
                prev_vld   = tx_valid_o;
                prev_stall = tx_valid_o && !tx_ready_i;
                prev_dat   = tx_data_o;
            end else begin
                prev_vld   = 1'b0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_bytes(input string nm, input string exp);
        int nd;
        logic [7:0] e;
        nd = 0;
        for (int i = 0; i < exp.len(); i++) begin
            e = exp.getc(i);
            if (e == "~") e = 8'h0D;
            if (i >= rx_q.size() || rx_q[i] !== e) nd++;
        end
        chk({nm, "_len"}, 64'(rx_q.size()), 64'(exp.len()));
        chk({nm, "_diff"}, 64'(nd), 64'd0);
    endtask

    task automatic env_reset(input bit st, input int ea, input bit ns);
        rx_q.delete();
        stall_en = st; err_at = ea; no_status = ns;
        st_dly = 0; st_hi = 0; er_dly = 0;
        obs_n = 0; done_n = 0; stab_bad = 0;
        ncr_cyc = 0; o_first_cyc = 0;
        msg_start = 1;
        status_injection_i = 1'b0;
    endtask

    task automatic start_camp(input logic [39:0] b, input logic [39:0] s, input logic [15:0] n);
        @(negedge clk);
        base_addr_i = b; step_i = s; num_inj_i = n; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        base_addr_i = ~b; step_i = ~s;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_valid"}, 64'(tx_valid_o), 64'd0);
        chk({nm, "_busy"}, 64'(busy_o), 64'd0);
        chk({nm, "_done"}, 64'(done_o), 64'd0);
        chk({nm, "_inj"}, 64'(inj_count_o), 64'd0);
        chk({nm, "_err"}, 64'(err_count_o), 64'd0);
        chk({nm, "_tmo"}, 64'(timeout_o), 64'd0);
        chk({nm, "_data"}, 64'(tx_data_o), 64'd0);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{"basic", 40'h00000000AB, 40'h1, 16'd1, 0, 0, 0,
                    "I~N 00000000AB~O~", 1, 0, 0};
        vecs[1] = '{"wrap", 40'hFFFFFFFFF0, 40'h10, 16'd3, 0, 0, 0,
                    "I~N FFFFFFFFF0~O~N 0000000000~O~N 0000000010~O~", 3, 0, 0};
        vecs[2] = '{"stall", 40'h00000000AB, 40'h1, 16'd1, 1, 0, 0,
                    "I~N 00000000AB~O~", 1, 0, 0};
        vecs[3] = '{"dut_err", 40'h0000000100, 40'h1, 16'd3, 0, 2, 0,
                    "I~N 0000000100~O~N 0000000101~O~N 0000000102~O~", 3, 1, 0};
        vecs[4] = '{"timeout", 40'h0000000005, 40'h1, 16'd2, 0, 0, 1,
                    "I~N 0000000005~O~", 0, 0, 1};

        rst = 1'b1; start_i = 1'b0;
        base_addr_i = '0; step_i = '0; num_inj_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk_idle_zero("reset");

        for (int v = 0; v < 5; v++) begin
            env_reset(vecs[v].stall, vecs[v].err_at, vecs[v].no_status);
            start_camp(vecs[v].base, vecs[v].step, vecs[v].num);
            wait_done(3000, ok);
            chk({vecs[v].name, "_done_seen"}, 64'(ok), 64'd1);
            chk({vecs[v].name, "_busy_at_done"}, 64'(busy_o), 64'd0);
            if (v == 0) begin
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                #2;
                chk("start_in_done_ignored", 64'(busy_o), 64'd0);
            end
            repeat (4) @(negedge clk);
            #2;
            chk_bytes(vecs[v].name, vecs[v].exp);
            chk({vecs[v].name, "_inj"}, 64'(inj_count_o), 64'(vecs[v].e_inj));
            chk({vecs[v].name, "_err"}, 64'(err_count_o), 64'(vecs[v].e_err));
            chk({vecs[v].name, "_tmo"}, 64'(timeout_o), 64'(vecs[v].e_tmo));
            chk({vecs[v].name, "_done_pulses"}, 64'(done_n), 64'd1);
            chk({vecs[v].name, "_stable"}, 64'(stab_bad), 64'd0);
            if (vecs[v].no_status)
                chk("timeout_latency", 64'(o_first_cyc - ncr_cyc), 64'd101);
        end

        // sticky timeout survives idle, then reset clears it
        chk("tmo_sticky_idle", 64'(timeout_o), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_idle_zero("rst_after_tmo");

        // start ignored while busy
        env_reset(0, 0, 0);
        start_camp(40'h1, 40'h1, 16'd1);
        repeat (8) @(negedge clk);
        base_addr_i = 40'h7; num_inj_i = 16'd5; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(3000, ok);
        chk("busy_start_done_seen", 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
        #2;
        chk_bytes("busy_start", "I~N 0000000001~O~");
        chk("busy_start_inj", 64'(inj_count_o), 64'd1);

        // reset in the middle of the N string
        env_reset(0, 0, 0);
        start_camp(40'hAB, 40'h1, 16'd1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (rx_q.size() >= 5) begin
                ok = 1;
                break;
            end
        end
        chk("mid_n_reached", 64'(ok), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_idle_zero("mid_rst");
        rx_q.delete();
        repeat (10) @(negedge clk);
        #2;
        chk("mid_rst_no_bytes", 64'(rx_q.size()), 64'd0);

        // zero-length campaign: done two cycles after start, no bytes
        env_reset(0, 0, 0);
        @(negedge clk);
        base_addr_i = 40'hAB; step_i = 40'h1; num_inj_i = 16'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #2;
        chk("num0_c1_done", 64'(done_o), 64'd0);
        chk("num0_c1_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        #2;
        chk("num0_c2_done", 64'(done_o), 64'd1);
        chk("num0_c2_busy", 64'(busy_o), 64'd0);
        repeat (5) @(negedge clk);
        #2;
        chk("num0_no_bytes", 64'(rx_q.size()), 64'd0);
        chk("num0_inj", 64'(inj_count_o), 64'd0);
        chk("num0_done_pulses", 64'(done_n), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
